// File: rtl/jupiter_pkg.sv
// Shared definitions for the video RAM arbiter: RAM geometry, RAM select
// encoding and the arbiter FSM state encoding.
package jupiter_pkg;

  localparam int RAM_AW = 10;
  localparam int RAM_DW = 8;

  localparam logic SEL_SCREEN = 1'b0;
  localparam logic SEL_CHAR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAITING = 3'd1,
    ST_READ1   = 3'd2,
    ST_READ2   = 3'd3,
    ST_DONE    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU-side bus between the Z80 bus decoder (master) and the video RAM
// arbiter (slave).
//
// Handshake: the master raises cpu_req with cpu_sel/cpu_we/cpu_addr/cpu_wdata
// stable and keeps them stable while cpu_req is high. The slave completes the
// access by raising cpu_ack (cpu_rdata valid for reads) and holds cpu_ack
// until the master drops cpu_req. Dropping cpu_req before cpu_ack aborts the
// access with no acknowledge. cpu_wait is the Z80 WAIT request for an access
// that is being held off.
interface vram_arbiter_if;
  import jupiter_pkg::*;

  logic              cpu_req;
  logic              cpu_sel;
  logic              cpu_we;
  logic [RAM_AW-1:0] cpu_addr;
  logic [RAM_DW-1:0] cpu_wdata;
  logic [RAM_DW-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;

  modport master (
    output cpu_req, cpu_sel, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait
  );

endinterface

// File: rtl/vram_wbuf.sv
// Single-entry posted write buffer. Holds one CPU write until the video
// scanner releases the RAMs, then drains it with a one-clock write strobe.
// Also reports whether a lookup {sel, addr} matches the pending entry so a
// read can be forwarded from the buffer.
module vram_wbuf
  import jupiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture,
  input  logic              cap_sel,
  input  logic [RAM_AW-1:0] cap_addr,
  input  logic [RAM_DW-1:0] cap_data,
  input  logic              vid_busy,
  input  logic              look_sel,
  input  logic [RAM_AW-1:0] look_addr,
  output logic              valid,
  output logic              buf_sel,
  output logic [RAM_AW-1:0] buf_addr,
  output logic [RAM_DW-1:0] buf_data,
  output logic              drain,
  output logic              hit
);

  // The entry leaves on the first clock the video side is idle.
  assign drain = valid & ~vid_busy;
  assign hit   = valid & (buf_sel == look_sel) & (buf_addr == look_addr);

  // Capture a new write or retire the pending one; capture only happens
  // while empty, so the two never coincide. Data is kept after the drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      buf_sel  <= SEL_SCREEN;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (capture) begin
      valid    <= 1'b1;
      buf_sel  <= cap_sel;
      buf_addr <= cap_addr;
      buf_data <= cap_data;
    end else if (drain) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the screen RAM and character RAM between the Z80 and the video
// scanner. Video owns both RAMs whenever vid_busy is high; CPU reads are held
// off with cpu_wait, CPU writes are posted into a one-entry write buffer.
module vram_arbiter
  import jupiter_pkg::*;
#(
  parameter bit WBUF_EN = 1'b1,
  parameter int WCNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_busy,
  input  logic [RAM_AW-1:0] vid_saddr,
  input  logic [RAM_AW-1:0] vid_caddr,
  vram_arbiter_if.slave     bus,
  output logic [RAM_AW-1:0] sram_addr,
  output logic              sram_we,
  output logic [RAM_DW-1:0] sram_din,
  input  logic [RAM_DW-1:0] sram_dout,
  output logic [RAM_AW-1:0] cram_addr,
  output logic              cram_we,
  output logic [RAM_DW-1:0] cram_din,
  input  logic [RAM_DW-1:0] cram_dout,
  output logic [WCNT_W-1:0] wait_cnt,
  output arb_state_t        dbg_state
);

  arb_state_t        state;
  logic              fwd;
  logic              wbuf_valid;
  logic              wbuf_sel;
  logic [RAM_AW-1:0] wbuf_addr;
  logic [RAM_DW-1:0] wbuf_data;
  logic              drain;
  logic              hit;
  logic              wr_go;
  logic              rd_fwd;
  logic              rd_ram;
  logic              capture;

  assign dbg_state = state;

  // A posted write is taken straight from IDLE even while video is busy;
  // a write that had to wait (or an unbuffered write) needs the RAMs free.
  assign wr_go   = bus.cpu_req & bus.cpu_we & ~wbuf_valid &
                   ((WBUF_EN & (state == ST_IDLE)) | ~vid_busy);
  assign capture = wr_go & ((state == ST_IDLE) | (state == ST_WAITING));

  // A read matching the buffered entry needs no RAM, so it ignores vid_busy.
  // A RAM read waits for video and for the buffer to drain first.
  assign rd_fwd  = bus.cpu_req & ~bus.cpu_we & hit;
  assign rd_ram  = bus.cpu_req & ~bus.cpu_we & ~hit & ~vid_busy & ~wbuf_valid;

  assign bus.cpu_wait = bus.cpu_req &
                        ((state == ST_WAITING) | (state == ST_READ1) | (state == ST_READ2));

  vram_wbuf u_wbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .cap_sel   (bus.cpu_sel),
    .cap_addr  (bus.cpu_addr),
    .cap_data  (bus.cpu_wdata),
    .vid_busy  (vid_busy),
    .look_sel  (bus.cpu_sel),
    .look_addr (bus.cpu_addr),
    .valid     (wbuf_valid),
    .buf_sel   (wbuf_sel),
    .buf_addr  (wbuf_addr),
    .buf_data  (wbuf_data),
    .drain     (drain),
    .hit       (hit)
  );

  // Access sequencing: grant, two-clock read pipeline, ack hold, aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      fwd           <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAITING: begin
          if (!bus.cpu_req) begin
            state <= ST_IDLE;
          end else if (capture) begin
            state       <= ST_DONE;
            bus.cpu_ack <= 1'b1;
          end else if (rd_fwd | rd_ram) begin
            state <= ST_READ1;
            fwd   <= rd_fwd;
          end else begin
            state <= ST_WAITING;
          end
        end
        ST_READ1: begin
          if (!bus.cpu_req)          state <= ST_IDLE;
          else if (vid_busy && !fwd) state <= ST_WAITING;
          else                       state <= ST_READ2;
        end
        ST_READ2: begin
          if (!bus.cpu_req) begin
            state <= ST_IDLE;
          end else if (vid_busy && !fwd) begin
            state <= ST_WAITING;
          end else begin
            state       <= ST_DONE;
            bus.cpu_ack <= 1'b1;
            if (fwd)                          bus.cpu_rdata <= wbuf_data;
            else if (bus.cpu_sel == SEL_CHAR) bus.cpu_rdata <= cram_dout;
            else                              bus.cpu_rdata <= sram_dout;
          end
        end
        ST_DONE: begin
          if (!bus.cpu_req) begin
            state       <= ST_IDLE;
            bus.cpu_ack <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of clocks spent with the Z80 held in WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (bus.cpu_wait && (wait_cnt != {WCNT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + WCNT_W'(1);
    end
  end

  // RAM port mux: video first, then the buffer drain, else the CPU address.
  always_comb begin
    sram_addr = bus.cpu_addr;
    cram_addr = bus.cpu_addr;
    if (vid_busy) begin
      sram_addr = vid_saddr;
      cram_addr = vid_caddr;
    end else if (wbuf_valid) begin
      if (wbuf_sel == SEL_CHAR) cram_addr = wbuf_addr;
      else                      sram_addr = wbuf_addr;
    end
    sram_we  = drain & (wbuf_sel == SEL_SCREEN);
    cram_we  = drain & (wbuf_sel == SEL_CHAR);
    sram_din = wbuf_data;
    cram_din = wbuf_data;
  end

endmodule
